mem_stage: RTL
==============

# mem_stage

Memory-access stage of the pipelined core, directly upstream of `mem_wb_reg`. It takes EX/MEM outputs and drives a single-outstanding req/ack data-memory port, performing byte/half/word store-strobe generation and load alignment/sign-extension. Its outputs feed the MEM/WB register. `mem_stall` freezes the upstream stages while an access is in flight.

## Interface
- `TIMEOUT_CYCLES`, 255: watchdog limit in WAIT; used only with `MEM_TIMEOUT_EN`.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `ex_mem_rs1`, `ex_mem_rs2`, `ex_mem_rd` in 5 each: register indices.
- `ex_mem_mem_to_reg`, `ex_mem_regwrite`, `ex_mem_memread`, `ex_mem_memwrite` in 1 each: control.
- `ex_mem_funct3` in 3: access size/sign.
- `ex_mem_alu_result` in 32: effective address, or ALU result.
- `ex_mem_rs2_data` in 32: store data.
- `dmem_req` out 1: request, registered.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_wdata` out 32: store data, replicated across lanes.
- `dmem_wstrb` out 4: byte enables; 0 for loads.
- `dmem_ack` in 1: access complete; read data valid this cycle.
- `dmem_rdata` in 32: read word.
- `mem_rs1`, `mem_rs2`, `mem_rd` out 5 each: pass-through to `mem_wb_reg`.
- `mem_mem_to_reg`, `mem_regwrite` out 1 each: control to `mem_wb_reg`; `mem_regwrite` is gated.
- `mem_alu_result` out 32: pass-through.
- `mem_read_data` out 32: aligned, extended load data.
- `mem_stall` out 1: hold upstream stages.
- `mem_fault` out 1: misaligned address or illegal funct3 on a memory op.
- `mem_bus_err` out 1: watchdog expiry; exists only with `MEM_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, WAIT. Reset puts the FSM in IDLE and clears `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, the latched offset/funct3 and the watchdog count to 0.
- Access = `ex_mem_memread | ex_mem_memwrite`. If both are set, treat as a load.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
- Fault conditions: illegal funct3; half with `addr[0]`=1; word with `addr[1:0]`≠0.
- IDLE with a legal access:
  - Latch address, data, strobes, we, `addr[1:0]` and funct3.
  - Move to WAIT; `dmem_req` goes 1 on the next edge.
  - `mem_stall`=1 this cycle.
- IDLE with a faulting access:
  - No request.
  - `mem_fault`=1 combinationally.
  - `mem_regwrite` forced 0.
  - No stall.
- WAIT:
  - Hold `dmem_req` and all `dmem_*` outputs stable.
  - On `dmem_ack`: drop `dmem_req` at the next edge, return to IDLE, `mem_stall`=0 in the ack cycle.
  - Without ack: `mem_stall`=1.
- Store strobes:
  - SB: `4'b0001<<off`, `wdata={4{rs2[7:0]}}`.
  - SH: `4'b0011<<off`, `wdata={2{rs2[15:0]}}`.
  - SW: `4'b1111`, `wdata=rs2`.
- Loads: select the byte/half of `dmem_rdata` by the latched offset, then sign- or zero-extend by the latched funct3. `mem_read_data` is valid in the ack cycle and 0 otherwise.
- `mem_regwrite = ex_mem_regwrite & ~mem_stall & ~mem_fault`; this inserts bubbles into `mem_wb_reg` while stalled. All other `mem_*` signals are combinational pass-throughs.
- Non-memory instructions pass through in the same cycle with no stall.
- `dmem_ack` in IDLE is ignored.

## Timing
- Non-memory instruction: 0 added cycles.
- Memory op: minimum 2 cycles.
  - Cycle 0: accept, stall.
  - Cycle 1: req=1; with ack, completes and stall=0.
- Each cycle of ack delay adds one stall cycle.
- `rst` asserted in WAIT: IDLE and `dmem_req`=0 at that edge; a coincident ack is discarded.
- Back-to-back memory ops: the next op is accepted in the cycle after the ack (IDLE), so `dmem_req` is deasserted for at least one cycle between requests.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - The watchdog counts cycles in WAIT without ack, and clears on leaving WAIT.
  - At count == `TIMEOUT_CYCLES`: drop `dmem_req`, go to IDLE, pulse `mem_bus_err` for 1 cycle, force `mem_regwrite`=0, and set `mem_stall`=0 in that cycle.
  - An ack in the same cycle as expiry wins: normal completion, no error.
- `MEM_TIMEOUT_EN` undefined: no counter and no `mem_bus_err` port; WAIT persists until ack.

## Test plan
- LW at 0x100, rd=5, ack in 1st req cycle, rdata=0xDEADBEEF:
  - Stall exactly 1 cycle.
  - Ack cycle: `mem_read_data`=0xDEADBEEF, `mem_regwrite`=1.
- LB at 0x103, rdata=0x80FFFFFF → `mem_read_data`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, rs2=0x1234ABCD → `dmem_addr`=0x200, `dmem_wstrb`=4'b1100, `dmem_wdata`=0xABCDABCD, `dmem_we`=1.
- LW at 0x101 → `mem_fault`=1, `mem_regwrite`=0, `dmem_req` stays 0, no stall.
- Ack delayed 3 cycles → `mem_stall` high for 4 cycles and `dmem_addr` stable throughout. Assert `rst` in the 2nd WAIT cycle → IDLE and `dmem_req`=0 at the next edge.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack → `mem_bus_err` pulses 1 cycle at expiry, `mem_stall` drops, and `dmem_req`=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding req/ack data port, store lane steering, load alignment.
// Optional watchdog on the WAIT state is enabled by defining MEM_TIMEOUT_EN.

module mem_stage_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] rs2,
    output logic        strb,
    output logic [7:0]  wbyte
);
    localparam logic [1:0] LN = 2'(LANE);

    always_comb begin
        strb  = 1'b1;
        wbyte = rs2[8*LANE +: 8];
        case (size)
            2'b00: begin
                strb  = (off == LN);
                wbyte = rs2[7:0];
            end
            2'b01: begin
                strb  = (off[1] == LN[1]);
                wbyte = rs2[8*(LANE%2) +: 8];
            end
            default: ;
        endcase
    end
endmodule

module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_mem_rs1,
    input  logic [4:0]  ex_mem_rs2,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_mem_to_reg,
    input  logic        ex_mem_regwrite,
    input  logic        ex_mem_memread,
    input  logic        ex_mem_memwrite,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_rs2_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  mem_rs1,
    output logic [4:0]  mem_rs2,
    output logic [4:0]  mem_rd,
    output logic        mem_mem_to_reg,
    output logic        mem_regwrite,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_read_data,
    output logic        mem_stall,
    output logic        mem_fault
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        mem_bus_err
`endif
);
    localparam int NUM_LANES = 4;

    typedef enum logic [0:0] {IDLE, WAIT} state_t;
    typedef struct packed {
        logic [1:0] off;
        logic [2:0] funct3;
    } ld_ctl_t;

    state_t  state, state_nxt;
    ld_ctl_t ld_q;
    logic    access, is_load, f3_legal, misalign, fault, accept, done, expire;
    logic [NUM_LANES-1:0]       strb_c;
    logic [NUM_LANES-1:0][7:0]  wdata_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign access  = ex_mem_memread | ex_mem_memwrite;
    assign is_load = ex_mem_memread;

    always_comb begin
        f3_legal = 1'b0;
        case (ex_mem_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = is_load;
            default:                f3_legal = 1'b0;
        endcase
    end

    assign misalign = (ex_mem_funct3[1:0] == 2'b01 && ex_mem_alu_result[0]) ||
                      (ex_mem_funct3[1:0] == 2'b10 && ex_mem_alu_result[1:0] != 2'b00);
    assign fault  = (state == IDLE) & access & (~f3_legal | misalign);
    assign accept = (state == IDLE) & access & ~fault;
    // Reset in WAIT discards a coincident ack.
    assign done   = (state == WAIT) & dmem_ack & ~rst;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mem_stage_lane #(.LANE(i)) u_lane (
            .size  (ex_mem_funct3[1:0]),
            .off   (ex_mem_alu_result[1:0]),
            .rs2   (ex_mem_rs2_data),
            .strb  (strb_c[i]),
            .wbyte (wdata_c[i])
        );
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    logic [CW-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt <= '0;
        else if (state == WAIT && !dmem_ack && !expire)
            wd_cnt <= wd_cnt + CW'(1);
        else
            wd_cnt <= '0;
    end

    assign expire      = (state == WAIT) & ~dmem_ack & ~rst & (wd_cnt == CW'(TIMEOUT_CYCLES));
    assign mem_bus_err = expire;
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = WAIT;
            WAIT: if (done || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            ld_q       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dmem_req   <= 1'b1;
                dmem_we    <= ~is_load;
                dmem_addr  <= {ex_mem_alu_result[31:2], 2'b00};
                dmem_wdata <= wdata_c;
                dmem_wstrb <= is_load ? 4'b0000 : strb_c;
                ld_q       <= {ex_mem_alu_result[1:0], ex_mem_funct3};
            end else if (done || expire) begin
                dmem_req <= 1'b0;
            end
        end
    end

    assign byte_sel = dmem_rdata[{ld_q.off, 3'b000} +: 8];
    assign half_sel = ld_q.off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        mem_read_data = '0;
        if (done) begin
            case (ld_q.funct3)
                3'b000:  mem_read_data = {{24{byte_sel[7]}}, byte_sel};
                3'b001:  mem_read_data = {{16{half_sel[15]}}, half_sel};
                3'b100:  mem_read_data = {24'b0, byte_sel};
                3'b101:  mem_read_data = {16'b0, half_sel};
                default: mem_read_data = dmem_rdata;
            endcase
        end
    end

    assign mem_stall      = accept | ((state == WAIT) & ~done & ~expire);
    assign mem_fault      = fault;
    assign mem_regwrite   = ex_mem_regwrite & ~mem_stall & ~fault & ~expire;
    assign mem_rs1        = ex_mem_rs1;
    assign mem_rs2        = ex_mem_rs2;
    assign mem_rd         = ex_mem_rd;
    assign mem_mem_to_reg = ex_mem_mem_to_reg;
    assign mem_alu_result = ex_mem_alu_result;
endmodule
